// File: rtl/mem_ctrl.sv
// Miss controller and arbiter between the I/D L1 caches and the single-ported main memory.
// Grants one line miss at a time (round-robin on ties), writes back a dirty D victim, then fills.
module mem_ctrl #(
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned LINE_W = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_miss,
  input  logic [15:0]            i_addr,
  input  logic                   d_miss,
  input  logic [15:0]            d_addr,
  input  logic                   d_victim_dirty,
  input  logic [TAG_W-1:0]       d_victim_tag,
  input  logic [LINE_W-1:0]      d_victim_line,
  input  logic                   mem_rdy,
  input  logic [LINE_W-1:0]      mem_rd_data,
  output logic [TAG_W+IDX_W-1:0] mem_addr,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [LINE_W-1:0]      mem_wdata,
  output logic                   i_fill_we,
  output logic                   d_fill_we,
  output logic [15:0]            fill_addr,
  output logic [LINE_W-1:0]      fill_line,
  output logic                   i_done,
  output logic                   d_done,
  output logic                   busy
);

  localparam int unsigned LA_W   = TAG_W + IDX_W;
  localparam int unsigned OFF_W  = 16 - LA_W;
  localparam int unsigned IDX_HI = 15 - TAG_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_UPDATE
  } state_t;

  state_t      state;
  logic        side;        // 1 = D side granted
  logic        last_grant;  // 1 = D served last
  logic [15:0] req_addr;
  logic        grant_d_c;

  // D wins when alone, or on a tie when I was served last
  always_comb grant_d_c = d_miss && (!i_miss || !last_grant);

  // Single-process FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      side       <= 1'b0;
      last_grant <= 1'b0;
      req_addr   <= '0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      i_fill_we  <= 1'b0;
      d_fill_we  <= 1'b0;
      fill_addr  <= '0;
      fill_line  <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      i_fill_we <= 1'b0;
      d_fill_we <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_miss || d_miss) begin
            busy <= 1'b1;
            side <= grant_d_c;
            if (grant_d_c) begin
              req_addr <= d_addr;
              if (d_victim_dirty) begin
                // victim tag/line are held in the write request registers
                state     <= S_WB;
                mem_we    <= 1'b1;
                mem_addr  <= {d_victim_tag, d_addr[IDX_HI -: IDX_W]};
                mem_wdata <= d_victim_line;
              end else begin
                state    <= S_FILL;
                mem_re   <= 1'b1;
                mem_addr <= d_addr[15 -: LA_W];
              end
            end else begin
              req_addr <= i_addr;
              state    <= S_FILL;
              mem_re   <= 1'b1;
              mem_addr <= i_addr[15 -: LA_W];
            end
          end
        end
        S_WB: begin
          if (mem_rdy) begin
            state     <= S_FILL;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_re    <= 1'b1;
            mem_addr  <= req_addr[15 -: LA_W];
          end
        end
        S_FILL: begin
          if (mem_rdy) begin
            state     <= S_UPDATE;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            fill_line <= mem_rd_data;
            fill_addr <= (req_addr >> OFF_W) << OFF_W;
            i_fill_we <= !side;
            i_done    <= !side;
            d_fill_we <= side;
            d_done    <= side;
          end
        end
        S_UPDATE: begin
          // misses are not sampled here; the cache drops its miss on this edge
          state      <= S_IDLE;
          last_grant <= side;
          busy       <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed vector table, tie/busy/reset sequences, and a randomized run
// checked cycle by cycle against a transaction-level model of the miss service protocol.
module tb_mem_ctrl;

  localparam int unsigned TAG_W  = 8;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned LINE_W = 64;
  localparam int unsigned LA_W   = TAG_W + IDX_W;

  logic              clk;
  logic              rst_n;
  logic              i_miss, d_miss, d_victim_dirty, mem_rdy;
  logic [15:0]       i_addr, d_addr;
  logic [TAG_W-1:0]  d_victim_tag;
  logic [LINE_W-1:0] d_victim_line, mem_rd_data;
  logic [LA_W-1:0]   mem_addr;
  logic              mem_re, mem_we, i_fill_we, d_fill_we, i_done, d_done, busy;
  logic [LINE_W-1:0] mem_wdata, fill_line;
  logic [15:0]       fill_addr;

  mem_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_addr(d_addr),
    .d_victim_dirty(d_victim_dirty), .d_victim_tag(d_victim_tag), .d_victim_line(d_victim_line),
    .mem_rdy(mem_rdy), .mem_rd_data(mem_rd_data),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .fill_addr(fill_addr), .fill_line(fill_line),
    .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: phase 0 idle, 1 writeback, 2 fetch, 3 fill/done cycle
  int          m_ph;
  logic        m_side, m_last, m_dirty;
  logic [15:0] m_addr;
  logic [7:0]  m_tag;
  logic [63:0] m_line, m_rd;

  // environment state
  int          cnt, cur_lat, fix_wb, fix_rd;
  logic        prev_req, prev_rdy, i_fw_prev, d_fw_prev;
  bit          rand_en, stray_en, stray_all, rd_fixed_en;
  logic [63:0] rd_fixed;

  typedef struct {
    bit          is_d;
    logic [15:0] addr;
    bit          dirty;
    logic [7:0]  tag;
    logic [63:0] vline;
    logic [63:0] rdata;
    int          wb_lat;
    int          rd_lat;
    logic [13:0] exp_wb;
    logic [13:0] exp_rd;
    logic [15:0] exp_fill;
    int          exp_done;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_last = 1'b0; m_side = 1'b0; m_dirty = 1'b0;
    m_addr = '0; m_tag = '0; m_line = '0; m_rd = '0;
    cnt = 0; cur_lat = 1; prev_req = 1'b0; prev_rdy = 1'b0;
    i_fw_prev = 1'b0; d_fw_prev = 1'b0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, check, then drive the next inputs.
  task automatic run_cycle();
    logic req;
    int   wb_a;
    @(posedge clk);
    #1;
    if (m_ph == 3) begin
      m_ph = 0; m_last = m_side;
    end else if (m_ph == 2 && mem_rdy) begin
      m_ph = 3; m_rd = mem_rd_data;
    end else if (m_ph == 1 && mem_rdy) begin
      m_ph = 2;
    end else if (m_ph == 0 && (i_miss || d_miss)) begin
      m_side  = (i_miss && d_miss) ? !m_last : d_miss;
      m_addr  = m_side ? d_addr : i_addr;
      m_dirty = m_side && d_victim_dirty;
      m_tag   = d_victim_tag;
      m_line  = d_victim_line;
      m_ph    = m_dirty ? 1 : 2;
    end
    chk("busy", 64'(busy), 64'(m_ph != 0));
    chk("mem_we", 64'(mem_we), 64'(m_ph == 1));
    chk("mem_re", 64'(mem_re), 64'(m_ph == 2));
    if (m_ph == 1) begin
      wb_a = int'(m_tag) * 64 + (int'(m_addr) / 4) % 64;
      chk("wb_addr", 64'(mem_addr), 64'(wb_a));
      chk("wb_data", mem_wdata, m_line);
    end
    if (m_ph == 2) chk("rd_addr", 64'(mem_addr), 64'(int'(m_addr) / 4));
    chk("i_fill_we", 64'(i_fill_we), 64'(m_ph == 3 && !m_side));
    chk("i_done", 64'(i_done), 64'(m_ph == 3 && !m_side));
    chk("d_fill_we", 64'(d_fill_we), 64'(m_ph == 3 && m_side));
    chk("d_done", 64'(d_done), 64'(m_ph == 3 && m_side));
    if (m_ph == 3) begin
      chk("fill_addr", 64'(fill_addr), 64'(int'(m_addr) - int'(m_addr) % 4));
      chk("fill_line", fill_line, m_rd);
    end
    // caches: drop the miss the cycle after their fill strobe, optionally raise new ones
    if (i_fw_prev) i_miss = 1'b0;
    if (d_fw_prev) d_miss = 1'b0;
    i_fw_prev = i_fill_we;
    d_fw_prev = d_fill_we;
    if (rand_en) begin
      if (!i_miss && $urandom_range(0, 3) == 0) begin
        i_miss = 1'b1; i_addr = 16'($urandom);
      end
      if (!d_miss && $urandom_range(0, 3) == 0) begin
        d_miss = 1'b1; d_addr = 16'($urandom);
        d_victim_dirty = 1'($urandom); d_victim_tag = 8'($urandom);
        d_victim_line = {$urandom, $urandom};
      end
    end
    // memory: ready after a per-request latency, stray ready pulses while idle
    req = mem_re || mem_we;
    if (req) begin
      if (!prev_req || prev_rdy) begin
        cnt = 0;
        if (mem_we) cur_lat = (fix_wb > 0) ? fix_wb : int'($urandom_range(1, 4));
        else        cur_lat = (fix_rd > 0) ? fix_rd : int'($urandom_range(1, 4));
      end
      cnt++;
      mem_rdy = (cnt >= cur_lat);
    end else begin
      mem_rdy = stray_all || (stray_en && $urandom_range(0, 3) == 0);
    end
    prev_req = req;
    prev_rdy = mem_rdy;
    mem_rd_data = rd_fixed_en ? rd_fixed : {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_miss = 1'b0; d_miss = 1'b0; mem_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int          n_done, done_cyc;
    bit          seen_we, seen_re, other;
    logic [13:0] wa, ra;
    logic [63:0] wd, fl;
    logic [15:0] fa;
    n_done = 0; done_cyc = -1; seen_we = 0; seen_re = 0; other = 0;
    wa = '0; ra = '0; wd = '0; fl = '0; fa = '0;
    fix_wb = v.wb_lat; fix_rd = v.rd_lat; rd_fixed_en = 1; rd_fixed = v.rdata;
    d_victim_dirty = v.dirty; d_victim_tag = v.tag; d_victim_line = v.vline;
    if (v.is_d) begin d_miss = 1'b1; d_addr = v.addr; end
    else begin i_miss = 1'b1; i_addr = v.addr; end
    for (int c = 1; c <= 40; c++) begin
      run_cycle();
      if (mem_we && !seen_we) begin seen_we = 1; wa = mem_addr; wd = mem_wdata; end
      if (mem_re && !seen_re) begin seen_re = 1; ra = mem_addr; end
      if (v.is_d ? d_done : i_done) begin
        n_done++; done_cyc = c; fa = fill_addr; fl = fill_line;
      end
      if (v.is_d ? i_fill_we : d_fill_we) other = 1;
      if (n_done > 0 && !i_miss && !d_miss && !busy) break;
    end
    $display("vector %0d: done after %0d cycles", id, done_cyc);
    chk("vec_done_cnt", 64'(n_done), 64'd1);
    chk("vec_done_cyc", 64'(done_cyc), 64'(v.exp_done));
    chk("vec_rd_addr", 64'(ra), 64'(v.exp_rd));
    chk("vec_fill_addr", 64'(fa), 64'(v.exp_fill));
    chk("vec_fill_line", fl, v.rdata);
    chk("vec_wb_seen", 64'(seen_we), 64'(v.is_d && v.dirty));
    if (v.is_d && v.dirty) begin
      chk("vec_wb_addr", 64'(wa), 64'(v.exp_wb));
      chk("vec_wb_data", wd, v.vline);
    end
    chk("vec_other_side", 64'(other), 64'd0);
    rd_fixed_en = 0; fix_wb = 0; fix_rd = 0;
  endtask

  // both misses raised together; returns after both are served
  task automatic run_pair(input logic exp_first, input string name);
    int first, n;
    first = -1; n = 0;
    i_addr = 16'($urandom); d_addr = 16'($urandom);
    d_victim_dirty = 1'b0;
    i_miss = 1'b1; d_miss = 1'b1; fix_rd = 2;
    for (int c = 0; c < 80; c++) begin
      run_cycle();
      if (i_done || d_done) begin
        if (first < 0) first = d_done ? 1 : 0;
        n++;
      end
      if (n >= 2 && !i_miss && !d_miss && !busy) break;
    end
    chk(name, 64'(first), 64'(exp_first));
    chk("pair_served_cnt", 64'(n), 64'd2);
    fix_rd = 0;
  endtask

  initial begin
    int dc, ic, ir, ni, nd, n_serv;
    vt[0] = '{1'b0, 16'h1234, 1'b0, 8'h00, 64'h0, 64'h1111_2222_3333_4444, 0, 4,
              14'h0000, 14'h048D, 16'h1234, 5};
    vt[1] = '{1'b1, 16'h0040, 1'b1, 8'hAB, 64'hDEAD_BEEF_0000_FFFF, 64'h0123_4567_89AB_CDEF, 3, 2,
              14'h2AD0, 14'h0010, 16'h0040, 6};
    vt[2] = '{1'b1, 16'hBEEF, 1'b0, 8'h12, 64'h5555, 64'hCAFE_F00D_1234_5678, 0, 1,
              14'h0000, 14'h2FBB, 16'hBEEC, 2};
    vt[3] = '{1'b1, 16'h0003, 1'b1, 8'hFF, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_0F0F_F0F0_F0F0, 1, 1,
              14'h3FC0, 14'h0000, 16'h0000, 3};
    vt[4] = '{1'b0, 16'hFFFF, 1'b1, 8'h77, 64'h1, 64'h8000_0000_0000_0001, 0, 2,
              14'h0000, 14'h3FFF, 16'hFFFC, 3};

    i_addr = '0; d_addr = '0; d_victim_dirty = 1'b0; d_victim_tag = '0; d_victim_line = '0;
    mem_rd_data = '0; rand_en = 0; stray_en = 1; stray_all = 0; rd_fixed_en = 0; rd_fixed = '0;
    fix_wb = 0; fix_rd = 0;
    do_reset();

    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_fill_line", fill_line, 64'd0);
    chk("rst_done", 64'({i_done, d_done, i_fill_we, d_fill_we}), 64'd0);

    // directed single misses
    for (int k = 0; k < 5; k++) run_vec(vt[k], k);

    // stray ready pulses while idle must do nothing
    stray_all = 1;
    repeat (8) begin
      run_cycle();
      chk("stray_idle_busy", 64'(busy), 64'd0);
    end
    stray_all = 0;

    // tie arbitration from reset: D first, D again after I served last, I first after D served last
    do_reset();
    run_pair(1'b1, "tie_after_reset");
    run_pair(1'b1, "tie_after_i_last");
    run_vec(vt[2], 2);
    run_pair(1'b0, "tie_after_d_last");

    // I miss rising during a D writeback waits for D's update
    fix_wb = 5; fix_rd = 2;
    d_victim_dirty = 1'b1; d_victim_tag = 8'h3C; d_victim_line = 64'h1234_5678_9ABC_DEF0;
    d_addr = 16'h0100; d_miss = 1'b1;
    run_cycle();
    run_cycle();
    chk("busy_in_wb", 64'(mem_we), 64'd1);
    i_addr = 16'h4444; i_miss = 1'b1;
    dc = -1; ic = -1; ir = -1; ni = 0; nd = 0;
    for (int c = 0; c < 60; c++) begin
      run_cycle();
      if (d_done) begin dc = c; nd++; end
      if (i_done) begin ic = c; ni++; end
      if (mem_re && dc >= 0 && ir < 0) ir = c;
      if (ni > 0 && !i_miss && !d_miss && !busy) break;
    end
    repeat (5) begin
      run_cycle();
      if (i_done) ni++;
    end
    chk("busy_d_done_cnt", 64'(nd), 64'd1);
    chk("busy_i_grant_cyc", 64'(ir), 64'(dc + 2));
    chk("busy_i_done_cnt", 64'(ni), 64'd1);
    fix_wb = 0; fix_rd = 0;

    // asynchronous reset while a fetch is outstanding
    fix_rd = 30;
    i_addr = 16'h0ABC; i_miss = 1'b1;
    for (int c = 0; c < 5; c++) begin
      run_cycle();
      if (mem_re) break;
    end
    chk("rst_mid_pre_re", 64'(mem_re), 64'd1);
    #2;
    rst_n = 1'b0;
    mem_rdy = 1'b0;
    #1;
    chk("rst_mid_re", 64'(mem_re), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_addr", 64'(mem_addr), 64'd0);
    chk("rst_mid_we_wdata", 64'({mem_we, mem_wdata != 64'd0}), 64'd0);
    chk("rst_mid_fill", 64'({fill_addr, i_fill_we, i_done, d_fill_we, d_done}), 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_hold_pulses", 64'({i_fill_we, i_done, busy}), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    fix_rd = 3;
    ni = 0;
    for (int c = 0; c < 20; c++) begin
      run_cycle();
      if (i_done) ni++;
      if (ni > 0 && !i_miss && !busy) break;
    end
    chk("rst_reserve_cnt", 64'(ni), 64'd1);
    fix_rd = 0;

    // randomized traffic against the model
    rand_en = 1;
    n_serv = 0;
    repeat (3000) begin
      run_cycle();
      if (i_done || d_done) n_serv++;
    end
    rand_en = 0;
    for (int c = 0; c < 300; c++) begin
      run_cycle();
      if (i_done || d_done) n_serv++;
      if (!i_miss && !d_miss && m_ph == 0 && !busy) break;
    end
    chk("rand_drained", 64'(!i_miss && !d_miss && m_ph == 0), 64'd1);
    chk("rand_progress", 64'(n_serv > 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Miss controller and arbiter between the two L1 caches (instruction and data) and the single-ported unified main memory in `sys_mem`. It accepts line-miss requests from both caches and grants one at a time, using round-robin on ties. For a dirty data-cache victim it writes the victim line back, then fetches the missing line and writes it into the requesting cache. Both caches stall on their miss signal until the controller pulses the matching done.

## Interface

Parameters:
- TAG_W, default 8, tag width. Address bits [15:16-TAG_W].
- IDX_W, default 6, index width. Address bits [15-TAG_W:16-TAG_W-IDX_W]. The remaining low bits are the word offset; 2 bits at the defaults.
- LINE_W, default 64, cache line / memory data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- i_miss  in  1  I-cache miss pending; held until i_done
- i_addr  in  16  I-side miss word address
- d_miss  in  1  D-cache miss pending (read or write); held until d_done
- d_addr  in  16  D-side miss word address
- d_victim_dirty  in  1  D-cache victim line at d_addr's index is valid and dirty
- d_victim_tag  in  TAG_W  tag of the D victim
- d_victim_line  in  LINE_W  data of the D victim
- mem_rdy  in  1  memory completed the held request this cycle
- mem_rd_data  in  LINE_W  memory read line; valid when mem_rdy and mem_re are both high
- mem_addr  out  TAG_W+IDX_W  line address to memory
- mem_re / mem_we  out  1  memory read / write request; held until mem_rdy
- mem_wdata  out  LINE_W  writeback data
- i_fill_we / d_fill_we  out  1  one-cycle cache line write strobe
- fill_addr  out  16  line address for the fill, offset bits 0
- fill_line  out  LINE_W  fetched line; the cache writes it valid and clean
- i_done / d_done  out  1  one-cycle completion pulse
- busy  out  1  state != IDLE

## Operation

- States: IDLE, WB, FILL, UPDATE.
- **IDLE, grant:**
  - Sample the misses. If only one is high, grant it.
  - If both are high, grant the side not served last. `last_grant` resets to I, so the first tie goes to D.
  - At grant, latch: side, request address, and for D also victim dirty, tag and line.
  - A D grant with dirty victim goes to WB. Any other grant goes to FILL.
- **WB:**
  - mem_we=1.
  - mem_addr = {victim_tag, req_addr index}.
  - mem_wdata = latched victim line.
  - On mem_rdy, go to FILL.
- **FILL:**
  - mem_re=1, mem_addr = req_addr[15:16-TAG_W-IDX_W].
  - On mem_rdy, register mem_rd_data into fill_line and go to UPDATE.
- **UPDATE (exactly one cycle):**
  - Assert the granted side's fill_we and done together.
  - fill_addr = latched address with offset cleared.
  - Update last_grant, then go to IDLE.
  - The cache writes on this edge, so its miss is low the following cycle.
- Memory handshake:
  - mem_re and mem_we are never high together.
  - The request is asserted from the state's first cycle and held stable until mem_rdy is sampled high. mem_rdy in that first cycle is legal.
  - mem_rdy is ignored when no request is asserted.
- Misses that rise while busy wait. No miss is lost or serviced twice.
- The controller never modifies data. The D-cache merges a pending store after the fill completes.
- Asynchronous reset:
  - Forces IDLE, clears the latches and deasserts all outputs immediately, including mid-WB or mid-FILL.
  - The aborted memory request is dropped. No fill_we or done is produced for it.

## Timing

- Every output resets to 0; fill_line also resets to 0.
- All outputs are registered.
- Clean miss: grant edge, then N cycles in FILL (mem_rdy in the Nth), then 1 UPDATE cycle.
  - Minimum: done 2 cycles after the miss is first sampled.
- Dirty miss: adds M cycles of WB before FILL. Minimum 3 cycles.
- The next grant is sampled in the IDLE cycle after UPDATE. There are no back-to-back UPDATE cycles.

## Test plan

1. **Clean I miss.** Stimulus: i_miss, i_addr=0x1234; memory returns 0x1111_2222_3333_4444 with mem_rdy on the 4th FILL cycle. Required:
   - mem_re with mem_addr=0x048D.
   - Then i_fill_we and i_done for one cycle, with fill_addr=0x1234 and fill_line=0x1111_2222_3333_4444.
   - d_fill_we stays 0.
2. **Dirty D miss.** Stimulus: d_addr=0x0040, victim tag 0xAB, line 0xDEAD_BEEF_0000_FFFF. Required:
   - mem_we with mem_addr=0x2AD0 and mem_wdata equal to the victim line, held until mem_rdy.
   - Then mem_re with mem_addr=0x0010.
   - d_fill_we and d_done in UPDATE.
3. **Simultaneous misses after reset.** Required:
   - D is served first, then I.
   - A second simultaneous pair is served I first only if the last grant was D; otherwise D first.
4. **Reset mid-FILL.** Stimulus: rst_n low while mem_re is held. Required:
   - All outputs drop to 0 without waiting for a clock edge.
   - No fill_we or done pulse.
   - After release, a still-asserted miss is served from IDLE again.
5. **Stray and early mem_rdy.** Required:
   - mem_rdy pulses while in IDLE cause no action.
   - mem_rdy in the first FILL cycle gives done 2 cycles after the miss is first sampled.
6. **Miss raised while busy.** Stimulus: i_miss rises during D's WB. Required: I is granted in the IDLE cycle after D's UPDATE, and is serviced exactly once.
